// File: rtl/cp_symbol_scheduler.sv
// Cyclic-prefix read sequencer: per symbol reads CP_LEN tail samples, then all N_FFT samples.
// Latency: frame_start -> first rd_en 2 cycles, out_valid 1 more; tx_en low freezes reads in place.
module cp_symbol_scheduler #(
    parameter int N_FFT          = 64,
    parameter int ADDR_W         = 6,
    parameter int CP_LEN         = 16,
    parameter int SYMS_PER_FRAME = 10,
    parameter int GAP_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              abort,
    input  logic              sym_ready,
    input  logic              tx_en,
    output logic              sym_release,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic              out_prefix,
    output logic [7:0]        sym_idx,
    output logic              busy,
    output logic              frame_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] PREFIX_BASE = ADDR_W'(N_FFT - CP_LEN);
    localparam logic [ADDR_W-1:0] CP_LAST     = ADDR_W'(CP_LEN - 1);
    localparam logic [ADDR_W-1:0] BODY_LAST   = ADDR_W'(N_FFT - 1);
    localparam logic [7:0]        SYM_LAST    = 8'(SYMS_PER_FRAME - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYM,
        S_PREFIX,
        S_BODY,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         sym_idx_q, sym_idx_d;
    logic               out_valid_q, out_valid_d;
    logic               out_prefix_q, out_prefix_d;
    logic               frame_done_q, frame_done_d;
    logic               last_rd;
    logic               prefix_rd;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sym_idx_d    = sym_idx_q;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        last_rd      = 1'b0;
        prefix_rd    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d   = S_WAIT_SYM;
                    sym_idx_d = '0;
                end
            end
            S_WAIT_SYM: begin
                if (sym_ready && tx_en) begin
                    state_d = S_PREFIX;
                    cnt_d   = '0;
                end
            end
            S_PREFIX: begin
                if (tx_en) begin
                    rd_en     = 1'b1;
                    prefix_rd = 1'b1;
                    rd_addr   = PREFIX_BASE + cnt_q;
                    if (cnt_q == CP_LAST) begin
                        state_d = S_BODY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (tx_en) begin
                    rd_en   = 1'b1;
                    rd_addr = cnt_q;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == BODY_LAST) begin
                        last_rd = 1'b1;
                        cnt_d   = '0;
                        if (sym_idx_q == SYM_LAST) begin
                            state_d      = S_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            sym_idx_d = sym_idx_q + 1'b1;
                            gap_cnt_d = '0;
                            state_d   = (GAP_CYCLES == 0) ? S_WAIT_SYM : S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                // Gap timing is wall-clock: tx_en does not stretch it.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_WAIT_SYM;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            gap_cnt_d    = '0;
            sym_idx_d    = '0;
            frame_done_d = 1'b0;
        end

        // An aborted frame must not hand its buffer back upstream.
        sym_release  = last_rd && !abort && !rst;
        out_valid_d  = rd_en && !abort;
        out_prefix_d = prefix_rd && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            sym_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_prefix_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sym_idx_q    <= sym_idx_d;
            out_valid_q  <= out_valid_d;
            out_prefix_q <= out_prefix_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_prefix = out_prefix_q;
    assign sym_idx    = sym_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cp_symbol_scheduler.sv
// Bench for cp_symbol_scheduler: two instances (CP 16 / gap 4 / 2 symbols, CP 64 / gap 0 / 3 symbols)
// checked each cycle against a per-symbol read-plan model plus directed timing checks.
module tb_cp_symbol_scheduler;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start [2];
    logic       abort       [2];
    logic       sym_ready   [2];
    logic       tx_en       [2];
    logic       o_rel       [2];
    logic       o_rd_en     [2];
    logic [5:0] o_rd_addr   [2];
    logic       o_ov        [2];
    logic       o_op        [2];
    logic [7:0] o_sym       [2];
    logic       o_busy      [2];
    logic       o_fd        [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: frame active, symbol started, position in the 0..CP+N-1 read plan.
    bit m_in [2];
    bit m_started [2];
    int m_pos [2];
    int m_gap [2];
    int m_sym [2];
    bit m_ov [2];
    bit m_op [2];
    bit m_fd [2];

    always #5 clk = ~clk;

    cp_symbol_scheduler #(.N_FFT(64), .ADDR_W(6), .CP_LEN(16), .SYMS_PER_FRAME(2), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start[0]), .abort(abort[0]),
        .sym_ready(sym_ready[0]), .tx_en(tx_en[0]), .sym_release(o_rel[0]), .rd_en(o_rd_en[0]),
        .rd_addr(o_rd_addr[0]), .out_valid(o_ov[0]), .out_prefix(o_op[0]), .sym_idx(o_sym[0]),
        .busy(o_busy[0]), .frame_done(o_fd[0])
    );

    cp_symbol_scheduler #(.N_FFT(64), .ADDR_W(6), .CP_LEN(64), .SYMS_PER_FRAME(3), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start[1]), .abort(abort[1]),
        .sym_ready(sym_ready[1]), .tx_en(tx_en[1]), .sym_release(o_rel[1]), .rd_en(o_rd_en[1]),
        .rd_addr(o_rd_addr[1]), .out_valid(o_ov[1]), .out_prefix(o_op[1]), .sym_idx(o_sym[1]),
        .busy(o_busy[1]), .frame_done(o_fd[1])
    );

    function automatic int cpl(int d);
        return (d == 0) ? 16 : 64;
    endfunction
    function automatic int gapc(int d);
        return (d == 0) ? 4 : 0;
    endfunction
    function automatic int syms(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [19:0] exp_vec(int d);
        logic       rd;
        logic [5:0] a;
        logic       rel;
        rd  = m_started[d] && tx_en[d];
        a   = rd ? 6'((m_pos[d] < cpl(d)) ? (N - cpl(d) + m_pos[d]) : (m_pos[d] - cpl(d))) : 6'd0;
        rel = rd && (m_pos[d] == cpl(d) + N - 1) && !abort[d] && !rst;
        return {rd, a, rel, m_ov[d], m_op[d], 8'(m_sym[d]), m_in[d], m_fd[d]};
    endfunction

    function automatic logic [19:0] obs_vec(int d);
        return {o_rd_en[d], o_rd_en[d] ? o_rd_addr[d] : 6'd0, o_rel[d], o_ov[d], o_op[d],
                o_sym[d], o_busy[d], o_fd[d]};
    endfunction

    task automatic model_update();
        bit rd;
        for (int d = 0; d < 2; d++) begin
            rd = m_started[d] && tx_en[d];
            if (rst || abort[d]) begin
                m_in[d] = 0; m_started[d] = 0; m_pos[d] = 0; m_gap[d] = 0;
                m_sym[d] = 0; m_ov[d] = 0; m_op[d] = 0; m_fd[d] = 0;
            end else begin
                m_ov[d] = rd;
                m_op[d] = rd && (m_pos[d] < cpl(d));
                m_fd[d] = 0;
                if (rd) begin
                    m_pos[d]++;
                    if (m_pos[d] == cpl(d) + N) begin
                        m_started[d] = 0;
                        m_pos[d] = 0;
                        if (m_sym[d] == syms(d) - 1) begin
                            m_in[d] = 0;
                            m_fd[d] = 1;
                        end else begin
                            m_sym[d]++;
                            m_gap[d] = gapc(d);
                        end
                    end
                end else if (m_in[d] && !m_started[d]) begin
                    if (m_gap[d] > 0) m_gap[d]--;
                    else if (sym_ready[d] && tx_en[d]) begin
                        m_started[d] = 1;
                        m_pos[d] = 0;
                    end
                end else if (!m_in[d] && frame_start[d]) begin
                    m_in[d] = 1;
                    m_sym[d] = 0;
                    m_gap[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic drive_idle();
        for (int d = 0; d < 2; d++) begin
            frame_start[d] = 0; abort[d] = 0; sym_ready[d] = 1; tx_en[d] = 1;
        end
    endtask

    task automatic quiesce();
        drive_idle();
        abort[0] = 1; abort[1] = 1;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        tick(); tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_vec(d) !== 20'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h exp 00000", d, obs_vec(d));
            end
        end
        tick();
        rst = 0;
    endtask

    task automatic test_nominal();
        int first_rd = -1, first_addr = -1, rel1 = -1, rel2 = -1, second = -1, done_k = -1;
        int pre_cnt = 0, ov_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            frame_start[0] = (k == 10) || (k > 10 && m_fd[0]);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL nominal_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (o_rd_en[0] && first_rd < 0) begin first_rd = k; first_addr = int'(o_rd_addr[0]); end
            if (o_rel[0] && rel1 < 0) rel1 = k;
            else if (o_rel[0] && rel2 < 0) rel2 = k;
            if (rel1 >= 0 && k > rel1 && o_rd_en[0] && second < 0) second = k;
            if (o_fd[0] && done_k < 0) done_k = k;
            if (k <= 178 && o_op[0]) pre_cnt++;
            if (k <= 178 && o_ov[0]) ov_cnt++;
            if (k == 178) begin
                checks++;
                if (o_busy[0] !== 1'b1 || o_sym[0] !== 8'd0) begin
                    errors++;
                    $display("FAIL restart_on_done busy %0b sym %0d exp busy 1 sym 0", o_busy[0], o_sym[0]);
                end
            end
            tick();
        end
        checks++; if (first_rd !== 12) begin errors++; $display("FAIL first_read_cycle got %0d exp 12", first_rd); end
        checks++; if (first_addr !== 48) begin errors++; $display("FAIL first_read_addr got %0d exp 48", first_addr); end
        checks++; if (rel1 !== 91) begin errors++; $display("FAIL release1_cycle got %0d exp 91", rel1); end
        checks++; if (second !== 97) begin errors++; $display("FAIL second_prefix_cycle got %0d exp 97", second); end
        checks++; if (rel2 !== 176) begin errors++; $display("FAIL release2_cycle got %0d exp 176", rel2); end
        checks++; if (done_k !== 177) begin errors++; $display("FAIL frame_done_cycle got %0d exp 177", done_k); end
        checks++; if (pre_cnt !== 32) begin errors++; $display("FAIL prefix_count got %0d exp 32", pre_cnt); end
        checks++; if (ov_cnt !== 160) begin errors++; $display("FAIL valid_count got %0d exp 160", ov_cnt); end
        quiesce();
    endtask

    task automatic test_stall();
        int stall_left = 0, reads = 0;
        bit stalled_once = 0, expect53 = 0, done_seen = 0;
        for (int k = 0; k < 400; k++) begin
            frame_start[0] = (k == 0);
            tx_en[0] = (stall_left == 0);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL stall_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (stall_left > 0) begin
                checks++;
                if (o_rd_en[0] !== 1'b0) begin errors++; $display("FAIL stall_rd_en got %0b exp 0", o_rd_en[0]); end
                stall_left--;
            end else if (o_rd_en[0]) begin
                reads++;
                if (expect53) begin
                    checks++;
                    if (o_rd_addr[0] !== 6'd53) begin errors++; $display("FAIL stall_resume_addr got %0d exp 53", o_rd_addr[0]); end
                    expect53 = 0;
                end
                if (!stalled_once && reads <= 16 && o_rd_addr[0] == 6'd52) begin
                    stall_left = 5; stalled_once = 1; expect53 = 1;
                end
            end
            if (o_rel[0]) begin
                checks++;
                if (reads !== 80) begin errors++; $display("FAIL reads_per_symbol got %0d exp 80", reads); end
                reads = 0;
            end
            if (o_fd[0]) begin done_seen = 1; tick(); break; end
            tick();
        end
        checks++;
        if (!done_seen || !stalled_once) begin
            errors++;
            $display("FAIL stall_frame_end done %0b stalled %0b exp 1 1", done_seen, stalled_once);
        end
        quiesce();
    endtask

    task automatic test_wait_sym();
        int hold = 0;
        bit held = 0, expect48 = 0, done_seen = 0;
        for (int k = 0; k < 400; k++) begin
            frame_start[0] = (k == 0);
            if (!held && m_in[0] && !m_started[0] && m_gap[0] == 0 && m_sym[0] == 1) begin
                hold = 20; held = 1; expect48 = 1;
            end
            sym_ready[0] = (hold == 0);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL wait_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (hold > 0) begin
                checks++;
                if (o_rd_en[0] !== 1'b0 || o_busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_hold rd_en %0b busy %0b exp 0 1", o_rd_en[0], o_busy[0]);
                end
                hold--;
            end else if (expect48 && o_rd_en[0]) begin
                checks++;
                if (o_rd_addr[0] !== 6'd48) begin errors++; $display("FAIL wait_first_addr got %0d exp 48", o_rd_addr[0]); end
                expect48 = 0;
            end
            if (o_fd[0]) begin done_seen = 1; tick(); break; end
            tick();
        end
        checks++;
        if (!done_seen || !held) begin errors++; $display("FAIL wait_frame_end done %0b held %0b exp 1 1", done_seen, held); end
        quiesce();
    endtask

    task automatic test_abort();
        bit fs_done = 0, ab_done = 0;
        int after = -1;
        for (int k = 0; k < 400; k++) begin
            frame_start[0] = (k == 0) || (after == 12);
            abort[0] = 0;
            if (!fs_done && m_started[0] && m_sym[0] == 1 && m_pos[0] == 16 + 10) begin
                frame_start[0] = 1; fs_done = 1;
            end
            if (!ab_done && m_started[0] && m_sym[0] == 1 && m_pos[0] == 16 + 30) begin
                abort[0] = 1; ab_done = 1; after = 0;
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL abort_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            if (after == 0) begin
                checks++;
                if (o_rd_en[0] !== 1'b1 || o_rd_addr[0] !== 6'd30 || o_sym[0] !== 8'd1) begin
                    errors++;
                    $display("FAIL abort_point rd_en %0b addr %0d sym %0d exp 1 30 1", o_rd_en[0], o_rd_addr[0], o_sym[0]);
                end
            end
            if (after == 1) begin
                checks++;
                if (o_busy[0] !== 1'b0 || o_ov[0] !== 1'b0 || o_sym[0] !== 8'd0) begin
                    errors++;
                    $display("FAIL abort_idle busy %0b valid %0b sym %0d exp 0 0 0", o_busy[0], o_ov[0], o_sym[0]);
                end
            end
            if (after >= 0 && after < 12) begin
                checks++;
                if (o_rel[0] !== 1'b0 || o_fd[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_pulse rel %0b done %0b exp 0 0", o_rel[0], o_fd[0]);
                end
            end
            if (after == 13) begin
                checks++;
                if (o_busy[0] !== 1'b1 || o_sym[0] !== 8'd0) begin
                    errors++;
                    $display("FAIL abort_restart busy %0b sym %0d exp 1 0", o_busy[0], o_sym[0]);
                end
                tick();
                break;
            end
            if (after >= 0) after++;
            tick();
        end
        checks++;
        if (after !== 13) begin errors++; $display("FAIL abort_reached got %0d exp 13", after); end
        quiesce();
    endtask

    task automatic test_overrides_rst();
        int first = -1, rel = -1, nxt = -1, post = -1;
        bit fired = 0;
        for (int k = 0; k < 400; k++) begin
            frame_start[1] = (k == 0);
            rst = 0;
            if (!fired && m_started[1] && m_sym[1] == 1 && m_pos[1] == 5) begin
                rst = 1; fired = 1; post = 0;
            end
            @(negedge clk);
            if (post != 1) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs_vec(d) !== exp_vec(d)) begin
                        errors++;
                        $display("FAIL ovr_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                    end
                end
            end
            if (o_rd_en[1] && first < 0) begin
                first = k;
                checks++;
                if (k !== 2 || o_rd_addr[1] !== 6'd0) begin
                    errors++;
                    $display("FAIL ovr_first_read cyc %0d addr %0d exp 2 0", k, o_rd_addr[1]);
                end
            end
            if (first >= 0 && k == first + 63) begin
                checks++;
                if (o_rd_addr[1] !== 6'd63 || o_op[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_prefix_end addr %0d prefix %0b exp 63 1", o_rd_addr[1], o_op[1]);
                end
            end
            if (o_rel[1] && rel < 0) rel = k;
            if (rel >= 0 && k > rel && o_rd_en[1] && nxt < 0) begin
                nxt = k;
                checks++;
                if (rel !== 129 || nxt !== 131) begin
                    errors++;
                    $display("FAIL ovr_no_gap release %0d next %0d exp 129 131", rel, nxt);
                end
            end
            if (post == 1) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs_vec(d) !== 20'h0) begin
                        errors++;
                        $display("FAIL rst_outputs dut%0d got %h exp 00000", d, obs_vec(d));
                    end
                end
                tick();
                break;
            end
            if (post >= 0) post++;
            tick();
        end
        rst = 0;
        checks++;
        if (post !== 1) begin errors++; $display("FAIL rst_reached got %0d exp 1", post); end
        quiesce();
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            for (int d = 0; d < 2; d++) begin
                tx_en[d]       = ($urandom_range(0, 9) != 0);
                sym_ready[d]   = ($urandom_range(0, 3) != 0);
                frame_start[d] = ($urandom_range(0, 7) == 0);
                abort[d]       = ($urandom_range(0, 599) == 0);
            end
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random_model dut%0d cyc %0d got %h exp %h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            tick();
        end
        rst = 0;
        quiesce();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_nominal();
        test_stall();
        test_wait_sym();
        test_abort();
        test_overrides_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp_symbol_scheduler.md
Name: cp_symbol_scheduler

Overview:
- Read-side sequencer for the transmitter's cyclic-prefix stage.
- Takes one IFFT output symbol of N_FFT samples from the symbol buffer and emits it as the last CP_LEN samples (the prefix) followed by all N_FFT samples (the body), i.e. N_FFT+CP_LEN samples per symbol.
- Generates the buffer read addresses and enables, counts symbols within a frame, inserts inter-symbol gap cycles, and hands each buffer back upstream when it has been fully read.

Parameters:
- N_FFT, 64, samples per OFDM symbol; must equal 2**ADDR_W.
- ADDR_W, 6, symbol-buffer address width.
- CP_LEN, 16, prefix length in samples; 1 <= CP_LEN <= N_FFT.
- SYMS_PER_FRAME, 10, symbols per frame; 1..256.
- GAP_CYCLES, 4, idle clock cycles between symbols; 0 means no gap.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- frame_start, input, 1, single-cycle pulse that starts a frame; honoured only in IDLE.
- abort, input, 1, synchronous frame abort.
- sym_ready, input, 1, upstream buffer holds a complete symbol.
- tx_en, input, 1, downstream enable; low stalls reads.
- sym_release, output, 1, one-cycle pulse: current buffer consumed.
- rd_en, output, 1, symbol-buffer read enable.
- rd_addr, output, ADDR_W, symbol-buffer read address.
- out_valid, output, 1, buffer data valid; equals rd_en delayed 1 cycle, matching the buffer's 1-cycle read latency.
- out_prefix, output, 1, high with out_valid when that sample belongs to the prefix.
- sym_idx, output, 8, index of the current symbol within the frame.
- busy, output, 1, high in any state other than IDLE.
- frame_done, output, 1, one-cycle pulse after the last read of the frame.

Behaviour:
- Reset values: state IDLE. rd_en, rd_addr, out_valid, out_prefix, sym_idx, sym_release, busy and frame_done are all 0. Internal counters are 0.
- States: IDLE, WAIT_SYM, PREFIX, BODY, GAP.
- IDLE:
  - frame_start=1 moves to WAIT_SYM next cycle and clears sym_idx to 0.
  - frame_start is ignored in every other state.
- WAIT_SYM: when sym_ready=1 and tx_en=1, move to PREFIX and clear the sample counter cnt.
- PREFIX:
  - In every cycle with tx_en=1: rd_en=1, rd_addr=N_FFT-CP_LEN+cnt, cnt increments.
  - After the read with cnt=CP_LEN-1, move to BODY with cnt=0.
- BODY:
  - In every cycle with tx_en=1: rd_en=1, rd_addr=cnt, cnt increments.
  - The read with cnt=N_FFT-1 is the last body read. In that same cycle sym_release=1.
  - If sym_idx=SYMS_PER_FRAME-1: go to IDLE and pulse frame_done in the next cycle; sym_idx holds its value.
  - Otherwise: sym_idx increments and the next state is GAP, or WAIT_SYM when GAP_CYCLES=0.
- rd_en and rd_addr are decoded combinationally from state, cnt and tx_en. rd_en=0 in every state other than PREFIX/BODY, and in PREFIX/BODY whenever tx_en=0.
- Stall: while tx_en=0 in PREFIX or BODY, cnt and state freeze. Reading resumes at the same address when tx_en returns to 1.
- GAP: counts GAP_CYCLES clock cycles regardless of tx_en, then moves to WAIT_SYM.
- out_valid and out_prefix are registered copies of rd_en and (state==PREFIX && rd_en).
- Latency:
  - frame_start sampled at cycle t puts the FSM in WAIT_SYM at t+1.
  - With sym_ready and tx_en high at t+1, the first rd_en (addr N_FFT-CP_LEN) occurs at t+2 and the first out_valid at t+3.
- Symbol period without stalls: 1 (WAIT_SYM) + CP_LEN + N_FFT + GAP_CYCLES cycles.
- sym_ready dropping during PREFIX or BODY is ignored; the buffer is committed until sym_release.
- abort:
  - Forces IDLE next cycle and clears cnt, sym_idx and the out_valid/out_prefix pipeline.
  - No sym_release and no frame_done are generated.
  - abort wins over frame_start in the same cycle.
- rst mid-operation: same effect as abort; all outputs return to their reset values.
- frame_start in the cycle frame_done is high: the FSM is already in IDLE, so the request is accepted and a new frame starts.

Test Plan:
- SYMS_PER_FRAME=2, GAP_CYCLES=4, tx_en=1, sym_ready=1, frame_start at t=10 -> rd_addr 48..63 then 0..63 from t=12; sym_release at t=91; next prefix reads from t=97; frame_done at t=177; out_valid lags rd_en by 1 cycle and out_prefix is high for exactly 16 samples per symbol.
- tx_en=0 for 5 cycles after prefix read addr 52 -> rd_en=0 for those cycles; resume reads at addr 53; no address skipped or repeated; total reads per symbol still 80.
- sym_ready=0 for 20 cycles after GAP -> FSM holds in WAIT_SYM with rd_en=0 and busy=1; the first read after sym_ready rises is addr 48.
- abort during BODY at addr 30 -> IDLE next cycle; sym_release and frame_done never pulse; out_valid=0 from the cycle after abort; a following frame_start restarts at sym_idx=0.
- frame_start pulsed during BODY -> ignored, sym_idx unaffected. frame_start in the frame_done cycle -> new frame begins, WAIT_SYM next cycle.
- rst held 1 cycle mid-PREFIX, plus GAP_CYCLES=0 and CP_LEN=N_FFT overrides -> all outputs at reset values the next cycle. With GAP_CYCLES=0, WAIT_SYM follows BODY directly. With CP_LEN=N_FFT, prefix addresses run 0..63.
